cnt_mod_n: RTL and testbench

Parametrised modulo-N cascadable counter for the digital-clock datapath, generalising the fixed mod-6 digit counter. It counts up or down on an incoming carry/enable pulse, supports synchronous preset for time setting, and emits a combinational carry/borrow so that seconds, minutes and hours stages chain on the same clock edge. It sits between the 1 Hz tick generator and the display decoder, with one instance per time field.

---
 rtl/clock_pkg.sv | 14 +
 rtl/bin2bcd2.sv | 14 +
 rtl/cnt_mod_n.sv | 73 +++++++
 tb/tb_cnt_mod_n.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared digital-clock datapath constants and the packed two-digit BCD type.
package clock_pkg;

  localparam int unsigned MOD_SEC  = 60;
  localparam int unsigned MOD_MIN  = 60;
  localparam int unsigned MOD_HOUR = 24;
  localparam int unsigned CNT_W    = 8;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

endpackage

// File: rtl/bin2bcd2.sv
// Combinational 0..99 binary to two-digit packed BCD converter; zero latency, no flow control.
module bin2bcd2
  import clock_pkg::*;
(
  input  logic [7:0] bin,
  output bcd_pair_t  bcd
);

  always_comb begin
    bcd.tens  = 4'(bin / 8'd10);
    bcd.units = 4'(bin % 8'd10);
  end

endmodule

// File: rtl/cnt_mod_n.sv
// Cascadable modulo-N up/down counter with range-checked preset; 1-cycle count/load, combinational carryout.
// Define BCD_OUT_EN to present out as packed BCD (MODULUS <= 100, WIDTH = 8); no backpressure.
module cnt_mod_n
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS = MOD_SEC,
  parameter int unsigned WIDTH   = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carryin,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             load_err
);

  localparam int unsigned CW = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [CW-1:0] MAX = CW'(MODULUS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_err_q, load_err_d;
  logic          load_ok;
  logic          at_term;

  always_comb begin
    load_ok    = 32'(load_val) < MODULUS;
    at_term    = up_dn ? (cnt_q == MAX) : (cnt_q == '0);
    cnt_d      = cnt_q;
    load_err_d = load_err_q;
    if (load) begin
      // An out-of-range preset leaves the count untouched and only flags the error.
      if (load_ok) begin
        cnt_d      = CW'(load_val);
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (carryin) begin
      if (up_dn) cnt_d = at_term ? '0  : cnt_q + CW'(1);
      else       cnt_d = at_term ? MAX : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end

  assign carryout = carryin & ~load & ~rst & at_term;
  assign load_err = load_err_q;

`ifdef BCD_OUT_EN
  bcd_pair_t bcd;

  bin2bcd2 u_bin2bcd2 (
    .bin (8'(cnt_q)),
    .bcd (bcd)
  );

  assign out = WIDTH'(bcd);
`else
  assign out = WIDTH'(cnt_q);
`endif

endmodule

// File: tb/tb_cnt_mod_n.sv
// Directed bench for cnt_mod_n: a mod-60 and a mod-24 instance driven side by side.
module tb_cnt_mod_n;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_carryin, a_up_dn, a_load;
  logic [7:0] a_load_val, a_out;
  logic       a_carryout, a_load_err;
  logic       b_carryin, b_up_dn, b_load;
  logic [7:0] b_load_val, b_out;
  logic       b_carryout, b_load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_mod_n #(.MODULUS(MOD_SEC), .WIDTH(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .carryin(a_carryin), .up_dn(a_up_dn), .load(a_load),
    .load_val(a_load_val), .out(a_out), .carryout(a_carryout), .load_err(a_load_err)
  );

  cnt_mod_n #(.MODULUS(MOD_HOUR), .WIDTH(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .carryin(b_carryin), .up_dn(b_up_dn), .load(b_load),
    .load_val(b_load_val), .out(b_out), .carryout(b_carryout), .load_err(b_load_err)
  );

  function automatic logic [7:0] enc(input int n);
`ifdef BCD_OUT_EN
    enc = 8'(((n / 10) << 4) | (n % 10));
`else
    enc = 8'(n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    a_carryin = 1'b1; a_up_dn = 1'b1; a_load = 1'b0; a_load_val = 8'd0;
    b_carryin = 1'b0; b_up_dn = 1'b1; b_load = 1'b0; b_load_val = 8'd0;

    // Reset held two edges with carryin active.
    tick(); tick();
    chk("rst_out", a_out, enc(0));
    chk("rst_carry", {7'd0, a_carryout}, 8'd0);
    chk("rst_err", {7'd0, a_load_err}, 8'd0);
    chk("rst_out_b", b_out, enc(0));

    // Count up to terminal and wrap.
    rst = 1'b0;
    #1 chk("carry_at_0", {7'd0, a_carryout}, 8'd0);
    tick();
    chk("first_count", a_out, enc(1));
    repeat (58) tick();
    chk("up_59", a_out, enc(59));
    chk("carry_59", {7'd0, a_carryout}, 8'd1);
    tick();
    chk("wrap_0", a_out, enc(0));
    chk("carry_after_wrap", {7'd0, a_carryout}, 8'd0);

    // Load range check with error hold.
    a_carryin = 1'b0; a_load = 1'b1; a_load_val = 8'd45;
    tick();
    chk("load45_out", a_out, enc(45));
    chk("load45_err", {7'd0, a_load_err}, 8'd0);
    a_load_val = 8'd60;
    tick();
    chk("load60_out", a_out, enc(45));
    chk("load60_err", {7'd0, a_load_err}, 8'd1);
    a_load = 1'b0; a_carryin = 1'b1;
    tick();
    chk("err_hold_out", a_out, enc(46));
    chk("err_hold_err", {7'd0, a_load_err}, 8'd1);
    a_carryin = 1'b0; a_load = 1'b1; a_load_val = 8'd0;
    tick();
    chk("load0_out", a_out, enc(0));
    chk("load0_err", {7'd0, a_load_err}, 8'd0);

    // Load beats count at terminal count.
    a_load_val = 8'd59;
    tick();
    a_load_val = 8'd10; a_carryin = 1'b1;
    #1 chk("prio_carry", {7'd0, a_carryout}, 8'd0);
    tick();
    chk("prio_out", a_out, enc(10));

    // Reset beats load, and clears a pending error.
    a_carryin = 1'b0; a_load_val = 8'd255;
    tick();
    chk("load255_err", {7'd0, a_load_err}, 8'd1);
    rst = 1'b1; a_load_val = 8'd33;
    tick();
    chk("rst_load_out", a_out, enc(0));
    chk("rst_load_err", {7'd0, a_load_err}, 8'd0);
    rst = 1'b0;

    // Hold for five cycles.
    a_load_val = 8'd30;
    tick();
    a_load = 1'b0;
    repeat (5) tick();
    chk("hold_out", a_out, enc(30));
    chk("hold_carry", {7'd0, a_carryout}, 8'd0);

    // Count down mid-range, then borrow masked by rst.
    a_up_dn = 1'b0; a_carryin = 1'b1;
    tick();
    chk("down_29", a_out, enc(29));
    rst = 1'b1;
    tick();
    chk("rst_mask_carry", {7'd0, a_carryout}, 8'd0);
    rst = 1'b0;
    #1 chk("borrow_at_0", {7'd0, a_carryout}, 8'd1);
    tick();
    chk("down_wrap_59", a_out, enc(59));
    a_carryin = 1'b0; a_up_dn = 1'b1;

    // Mod-24 instance: down wrap, up wrap, range check.
    b_up_dn = 1'b0; b_carryin = 1'b1;
    #1 chk("b_borrow_0", {7'd0, b_carryout}, 8'd1);
    tick();
    chk("b_down_23", b_out, enc(23));
    chk("b_carry_23_down", {7'd0, b_carryout}, 8'd0);
    b_up_dn = 1'b1;
    #1 chk("b_carry_23_up", {7'd0, b_carryout}, 8'd1);
    tick();
    chk("b_up_wrap", b_out, enc(0));
    b_carryin = 1'b0; b_load = 1'b1; b_load_val = 8'd24;
    tick();
    chk("b_load24_out", b_out, enc(0));
    chk("b_load24_err", {7'd0, b_load_err}, 8'd1);
    b_load_val = 8'd23;
    tick();
    chk("b_load23_out", b_out, enc(23));
    chk("b_load23_err", {7'd0, b_load_err}, 8'd0);
    b_load = 1'b0;

    // Output encoding walk: 47 -> 59 -> 0.
    a_load = 1'b1; a_load_val = 8'd47;
    tick();
    chk("enc_47", a_out, enc(47));
    a_load = 1'b0; a_carryin = 1'b1;
    repeat (12) tick();
    chk("enc_59", a_out, enc(59));
    tick();
    chk("enc_00", a_out, enc(0));
    a_carryin = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
